lmb_bram_dualport_ctrl: RTL and testbench

LMB_BRAM_DUALPORT_CTRL -- requirements
Module: lmb_bram_dualport_ctrl

---
 rtl/lmb_bram_dualport_ctrl_if.sv | 41 ++++
 rtl/lmb_bram_dualport_ctrl.sv | 123 ++++++++++++
 tb/tb_lmb_bram_dualport_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/lmb_bram_dualport_ctrl_if.sv
// Purpose: bundles both request ports plus the status outputs of the dual-port LMB BRAM.
// Latency: n/a (wiring only); the master drives EN/WEN/Addr/Dout, the slave returns Din/Rd_Valid.
// Backpressure: none, the memory accepts a request on every cycle of each port once Init_Done is high.
// Ports: master = bus controller side, slave = memory side. Vectors use ascending [0:N-1] numbering,
// so bit 0 of WEN selects data byte [0:7], the most significant byte.
interface lmb_bram_dualport_ctrl_if #(
    parameter int C_PORT_DWIDTH = 32,
    parameter int C_PORT_AWIDTH = 32,
    parameter int C_NUM_WE      = C_PORT_DWIDTH / 8
) ();
    logic                     BRAM_EN_A;
    logic [0:C_NUM_WE-1]      BRAM_WEN_A;
    logic [0:C_PORT_AWIDTH-1] BRAM_Addr_A;
    logic [0:C_PORT_DWIDTH-1] BRAM_Dout_A;
    logic [0:C_PORT_DWIDTH-1] BRAM_Din_A;
    logic                     Rd_Valid_A;

    logic                     BRAM_EN_B;
    logic [0:C_NUM_WE-1]      BRAM_WEN_B;
    logic [0:C_PORT_AWIDTH-1] BRAM_Addr_B;
    logic [0:C_PORT_DWIDTH-1] BRAM_Dout_B;
    logic [0:C_PORT_DWIDTH-1] BRAM_Din_B;
    logic                     Rd_Valid_B;

    logic                     Init_Done;
    logic                     Collision;

    modport master (
        output BRAM_EN_A, BRAM_WEN_A, BRAM_Addr_A, BRAM_Dout_A,
        output BRAM_EN_B, BRAM_WEN_B, BRAM_Addr_B, BRAM_Dout_B,
        input  BRAM_Din_A, Rd_Valid_A, BRAM_Din_B, Rd_Valid_B,
        input  Init_Done, Collision
    );

    modport slave (
        input  BRAM_EN_A, BRAM_WEN_A, BRAM_Addr_A, BRAM_Dout_A,
        input  BRAM_EN_B, BRAM_WEN_B, BRAM_Addr_B, BRAM_Dout_B,
        output BRAM_Din_A, Rd_Valid_A, BRAM_Din_B, Rd_Valid_B,
        output Init_Done, Collision
    );
endinterface

// File: rtl/lmb_bram_dualport_ctrl.sv
// Purpose: true dual-port byte-writable BRAM for LMB, read-first, optional zero-fill after reset.
// Latency: read data + Rd_Valid_x exactly C_READ_LATENCY (1 or 2) cycles after the request edge.
// Backpressure: none; requests are ignored (not stalled) until Init_Done is high.
// Ports: BRAM_Clk (rising edge), BRAM_Rst (sync, active high), bus (slave modport: EN/WEN/Addr/Dout
// in per port, Din/Rd_Valid out per port, Init_Done, Collision).
module lmb_bram_dualport_ctrl #(
    parameter int C_MEMSIZE      = 'h4000,
    parameter int C_PORT_DWIDTH  = 32,
    parameter int C_PORT_AWIDTH  = 32,
    parameter int C_NUM_WE       = C_PORT_DWIDTH / 8,
    parameter int C_READ_LATENCY = 1,
    parameter int C_INIT_ZERO    = 1
) (
    input  logic                     BRAM_Clk,
    input  logic                     BRAM_Rst,
    lmb_bram_dualport_ctrl_if.slave  bus
);
    localparam int D    = C_MEMSIZE / C_NUM_WE;
    localparam int IDXW = (D > 1) ? $clog2(D) : 1;
    localparam int OFF  = (C_NUM_WE > 1) ? $clog2(C_NUM_WE) : 0;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(D - 1);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t          state;
    logic [IDXW-1:0] clr_cnt;
    logic            init_done;

    logic [0:C_PORT_DWIDTH-1] mem [0:D-1];

    // First read stage, only used when C_READ_LATENCY == 2.
    logic                     s1_vld_a, s1_vld_b;
    logic [0:C_PORT_DWIDTH-1] s1_dat_a, s1_dat_b;

    // Copy addresses into descending vectors so bit significance is explicit when slicing the index.
    logic [C_PORT_AWIDTH-1:0] addr_a_num, addr_b_num;
    logic [IDXW-1:0]          idx_a, idx_b;
    logic                     acc_a, acc_b;
    logic                     collide;

    assign addr_a_num = bus.BRAM_Addr_A;
    assign addr_b_num = bus.BRAM_Addr_B;
    // Bits below OFF select a byte inside the word, bits above the index range alias (wrap mod D).
    assign idx_a      = addr_a_num[OFF +: IDXW];
    assign idx_b      = addr_b_num[OFF +: IDXW];

    // init_done is only ever high in RUN; the reset term blocks a write on the edge reset asserts.
    assign acc_a   = init_done && !BRAM_Rst && bus.BRAM_EN_A;
    assign acc_b   = init_done && !BRAM_Rst && bus.BRAM_EN_B;
    assign collide = acc_a && acc_b && (idx_a == idx_b) && (|(bus.BRAM_WEN_A & bus.BRAM_WEN_B));

    assign bus.Init_Done = init_done;

    // Memory array: no reset so it maps onto block RAM. Port A is written after port B so that
    // lanes enabled on both ports of the same word keep A's data.
    always_ff @(posedge BRAM_Clk) begin
        if (!BRAM_Rst) begin
            if (state == CLEAR) begin
                mem[clr_cnt] <= '0;
            end else begin
                for (int l = 0; l < C_NUM_WE; l++) begin
                    if (acc_b && bus.BRAM_WEN_B[l])
                        mem[idx_b][8*l +: 8] <= bus.BRAM_Dout_B[8*l +: 8];
                    if (acc_a && bus.BRAM_WEN_A[l])
                        mem[idx_a][8*l +: 8] <= bus.BRAM_Dout_A[8*l +: 8];
                end
            end
        end
    end

    // Control FSM with registered outputs. Reads sample mem before the same-edge write lands,
    // which gives read-first behaviour on both ports, including cross-port read/write.
    always_ff @(posedge BRAM_Clk) begin
        if (BRAM_Rst) begin
            state          <= (C_INIT_ZERO != 0) ? CLEAR : RUN;
            clr_cnt        <= '0;
            init_done      <= 1'b0;
            s1_vld_a       <= 1'b0;
            s1_vld_b       <= 1'b0;
            s1_dat_a       <= '0;
            s1_dat_b       <= '0;
            bus.BRAM_Din_A <= '0;
            bus.BRAM_Din_B <= '0;
            bus.Rd_Valid_A <= 1'b0;
            bus.Rd_Valid_B <= 1'b0;
            bus.Collision  <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + IDXW'(1);
                    if (clr_cnt == LAST_IDX) begin
                        state     <= RUN;
                        init_done <= 1'b1;
                    end
                end
                RUN: begin
                    init_done <= 1'b1;
                end
                default: state <= CLEAR;
            endcase

            bus.Collision <= collide;

            s1_vld_a <= acc_a;
            s1_vld_b <= acc_b;
            if (acc_a) s1_dat_a <= mem[idx_a];
            if (acc_b) s1_dat_b <= mem[idx_b];

            // Din only changes when a read completes, so it holds the last read value.
            if (C_READ_LATENCY == 2) begin
                bus.Rd_Valid_A <= s1_vld_a;
                bus.Rd_Valid_B <= s1_vld_b;
                if (s1_vld_a) bus.BRAM_Din_A <= s1_dat_a;
                if (s1_vld_b) bus.BRAM_Din_B <= s1_dat_b;
            end else begin
                bus.Rd_Valid_A <= acc_a;
                bus.Rd_Valid_B <= acc_b;
                if (acc_a) bus.BRAM_Din_A <= mem[idx_a];
                if (acc_b) bus.BRAM_Din_B <= mem[idx_b];
            end
        end
    end
endmodule

// File: tb/tb_lmb_bram_dualport_ctrl.sv
// Purpose: self-checking bench for lmb_bram_dualport_ctrl (default instance + latency-2 no-init instance).
// Latency: reference model predicts read data one cycle after each request on the default instance.
// Backpressure: none modelled; stimulus issues a request every cycle where desired.
module tb_lmb_bram_dualport_ctrl;
    logic clk  = 1'b0;
    logic rst0 = 1'b1;
    logic rst1 = 1'b1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lmb_bram_dualport_ctrl_if #(.C_PORT_DWIDTH(32), .C_PORT_AWIDTH(32), .C_NUM_WE(4)) bus0 ();
    lmb_bram_dualport_ctrl_if #(.C_PORT_DWIDTH(32), .C_PORT_AWIDTH(32), .C_NUM_WE(4)) bus1 ();

    lmb_bram_dualport_ctrl dut0 (
        .BRAM_Clk (clk),
        .BRAM_Rst (rst0),
        .bus      (bus0)
    );

    lmb_bram_dualport_ctrl #(
        .C_MEMSIZE      ('h100),
        .C_READ_LATENCY (2),
        .C_INIT_ZERO    (0)
    ) dut1 (
        .BRAM_Clk (clk),
        .BRAM_Rst (rst1),
        .bus      (bus1)
    );

    // Reference model for dut0: 4096 words, byte 0 = most significant byte.
    logic [31:0] model_mem [4096];
    logic [31:0] exp_din_a, exp_din_b;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // wen[k] enables the byte at value bits 8k+7:8k (wen written MSB-first as lane 0..3).
    function automatic logic [31:0] lane_mask(input logic [3:0] wen);
        logic [31:0] m = 32'h0;
        for (int k = 0; k < 4; k++)
            if (wen[k]) m |= (32'hFF << (8 * k));
        return m;
    endfunction

    function automatic int word_of(input logic [31:0] addr);
        return int'((addr / 4) % 4096);
    endfunction

    task automatic model_reset;
        for (int i = 0; i < 4096; i++) model_mem[i] = 32'h0;
        exp_din_a = 32'h0;
        exp_din_b = 32'h0;
    endtask

    // One request cycle on dut0: predict, drive, clock, compare all outputs.
    task automatic cyc0(input logic ea, input logic [3:0] wa, input logic [31:0] aa, input logic [31:0] da,
                        input logic eb, input logic [3:0] wb, input logic [31:0] ab, input logic [31:0] db);
        int ia = word_of(aa);
        int ib = word_of(ab);
        logic [31:0] ma = ea ? lane_mask(wa) : 32'h0;
        logic [31:0] mb = eb ? lane_mask(wb) : 32'h0;
        logic exp_col;
        if (ea) exp_din_a = model_mem[ia];
        if (eb) exp_din_b = model_mem[ib];
        exp_col = (ia == ib) && ((ma & mb) != 32'h0);
        if (ia == ib) begin
            model_mem[ia] = (model_mem[ia] & ~(ma | mb)) | (da & ma) | (db & mb & ~ma);
        end else begin
            model_mem[ia] = (model_mem[ia] & ~ma) | (da & ma);
            model_mem[ib] = (model_mem[ib] & ~mb) | (db & mb);
        end
        bus0.BRAM_EN_A = ea; bus0.BRAM_WEN_A = wa; bus0.BRAM_Addr_A = aa; bus0.BRAM_Dout_A = da;
        bus0.BRAM_EN_B = eb; bus0.BRAM_WEN_B = wb; bus0.BRAM_Addr_B = ab; bus0.BRAM_Dout_B = db;
        tick();
        check("rd_valid_a", bus0.Rd_Valid_A, ea);
        check("din_a", bus0.BRAM_Din_A, exp_din_a);
        check("rd_valid_b", bus0.Rd_Valid_B, eb);
        check("din_b", bus0.BRAM_Din_B, exp_din_b);
        check("collision", bus0.Collision, exp_col);
    endtask

    task automatic idle0;
        cyc0(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    // Release reset on dut0 with ports busy, count cycles until Init_Done.
    task automatic wait_init0(input string tag);
        int n = 0;
        logic saw_vld = 1'b0;
        bus0.BRAM_EN_A = 1'b1; bus0.BRAM_WEN_A = 4'hF; bus0.BRAM_Addr_A = 32'h0; bus0.BRAM_Dout_A = 32'hFFFFFFFF;
        bus0.BRAM_EN_B = 1'b1; bus0.BRAM_WEN_B = 4'h0; bus0.BRAM_Addr_B = 32'h4; bus0.BRAM_Dout_B = 32'h0;
        rst0 = 1'b0;
        while (!bus0.Init_Done && n < 6000) begin
            tick();
            n++;
            if (bus0.Rd_Valid_A || bus0.Rd_Valid_B) saw_vld = 1'b1;
        end
        check(tag, n, 4096);
        check("clear_no_valid", saw_vld, 1'b0);
        bus0.BRAM_EN_A = 1'b0;
        bus0.BRAM_EN_B = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [31:0] v [3];
        bus0.BRAM_EN_A = 0; bus0.BRAM_WEN_A = 0; bus0.BRAM_Addr_A = 0; bus0.BRAM_Dout_A = 0;
        bus0.BRAM_EN_B = 0; bus0.BRAM_WEN_B = 0; bus0.BRAM_Addr_B = 0; bus0.BRAM_Dout_B = 0;
        bus1.BRAM_EN_A = 0; bus1.BRAM_WEN_A = 0; bus1.BRAM_Addr_A = 0; bus1.BRAM_Dout_A = 0;
        bus1.BRAM_EN_B = 0; bus1.BRAM_WEN_B = 0; bus1.BRAM_Addr_B = 0; bus1.BRAM_Dout_B = 0;

        // Reset state.
        repeat (3) tick();
        check("rst_din_a", bus0.BRAM_Din_A, 32'h0);
        check("rst_din_b", bus0.BRAM_Din_B, 32'h0);
        check("rst_valid_a", bus0.Rd_Valid_A, 1'b0);
        check("rst_valid_b", bus0.Rd_Valid_B, 1'b0);
        check("rst_init_done", bus0.Init_Done, 1'b0);
        check("rst_collision", bus0.Collision, 1'b0);

        // Zero-fill, then read the last word in the first RUN cycle; writes during clear ignored.
        wait_init0("init_latency");
        cyc0(1'b1, 4'h0, 32'h3FFC, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        check("word4095_zero", bus0.BRAM_Din_A, 32'h0);
        cyc0(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h0, 32'h0);
        check("word0_untouched", bus0.BRAM_Din_B, 32'h0);

        // Full write on A, read on B, then a single-lane update.
        cyc0(1'b1, 4'b1111, 32'h10, 32'hDEADBEEF, 1'b0, 4'h0, 32'h0, 32'h0);
        cyc0(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h10, 32'h0);
        check("a_wr_b_rd", bus0.BRAM_Din_B, 32'hDEADBEEF);
        cyc0(1'b1, 4'b0100, 32'h10, 32'h00AA0000, 1'b0, 4'h0, 32'h0, 32'h0);
        cyc0(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h13, 32'h0);
        check("lane1_merge", bus0.BRAM_Din_B, 32'hDEAABEEF);

        // Same-word dual write with one overlapping lane.
        cyc0(1'b1, 4'b1100, 32'h20, 32'h11223344, 1'b1, 4'b0110, 32'h20, 32'h55667788);
        check("collision_pulse", bus0.Collision, 1'b1);
        idle0();
        check("collision_once", bus0.Collision, 1'b0);
        cyc0(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h20, 32'h0);
        check("dual_write_merge", bus0.BRAM_Din_B, 32'h11227700);

        // Cross-port read of a word being written returns the old contents.
        cyc0(1'b1, 4'b1111, 32'h30, 32'h12345678, 1'b1, 4'h0, 32'h30, 32'h0);
        check("read_old", bus0.BRAM_Din_B, 32'h0);
        cyc0(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h30, 32'h0);
        check("read_new", bus0.BRAM_Din_B, 32'h12345678);

        // Random traffic on a few words with aliased high bits and junk low bits.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] aa, ab;
            aa = ($urandom_range(0, 3) << 14) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            ab = ($urandom_range(0, 3) << 14) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            cyc0($urandom_range(0, 3) != 0, 4'($urandom), aa, $urandom,
                 $urandom_range(0, 3) != 0, 4'($urandom), ab, $urandom);
        end

        // Reset in the middle of the zero-fill restarts it.
        rst0 = 1'b1;
        tick();
        rst0 = 1'b0;
        repeat (1000) tick();
        rst0 = 1'b1;
        repeat (2) tick();
        check("midclr_din_a", bus0.BRAM_Din_A, 32'h0);
        check("midclr_din_b", bus0.BRAM_Din_B, 32'h0);
        check("midclr_valid_a", bus0.Rd_Valid_A, 1'b0);
        check("midclr_init_done", bus0.Init_Done, 1'b0);
        check("midclr_collision", bus0.Collision, 1'b0);
        wait_init0("reinit_latency");
        cyc0(1'b1, 4'b1111, 32'h4000, 32'hCAFEF00D, 1'b0, 4'h0, 32'h0, 32'h0);
        cyc0(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h0, 32'h0);
        check("alias_word0", bus0.BRAM_Din_B, 32'hCAFEF00D);

        // Latency-2, no zero-fill instance.
        check("l2_rst_init_done", bus1.Init_Done, 1'b0);
        rst1 = 1'b0;
        tick();
        check("l2_init_one_cycle", bus1.Init_Done, 1'b1);
        v[0] = 32'hA5A50001; v[1] = 32'h5A5A0002; v[2] = 32'h0F0F0003;
        for (int k = 0; k < 3; k++) begin
            bus1.BRAM_EN_A = 1'b1; bus1.BRAM_WEN_A = 4'hF;
            bus1.BRAM_Addr_A = 32'(4 * k); bus1.BRAM_Dout_A = v[k];
            tick();
        end
        bus1.BRAM_EN_A = 1'b0; bus1.BRAM_WEN_A = 4'h0;
        repeat (3) tick();
        for (int t = 0; t < 5; t++) begin
            bus1.BRAM_EN_A = (t < 3);
            bus1.BRAM_Addr_A = 32'(4 * t);
            tick();
            if (t == 0) check("l2_no_early_valid", bus1.Rd_Valid_A, 1'b0);
            if (t >= 1 && t <= 3) begin
                check("l2_stream_valid", bus1.Rd_Valid_A, 1'b1);
                check("l2_stream_data", bus1.BRAM_Din_A, v[t-1]);
            end
            if (t == 4) begin
                check("l2_stream_end", bus1.Rd_Valid_A, 1'b0);
                check("l2_hold", bus1.BRAM_Din_A, v[2]);
            end
        end
        bus1.BRAM_EN_A = 1'b0;

        // Without zero-fill, reset leaves memory contents alone.
        rst1 = 1'b1;
        repeat (2) tick();
        check("l2_rst_din", bus1.BRAM_Din_A, 32'h0);
        rst1 = 1'b0;
        tick();
        check("l2_reinit", bus1.Init_Done, 1'b1);
        bus1.BRAM_EN_A = 1'b1; bus1.BRAM_Addr_A = 32'h4;
        tick();
        bus1.BRAM_EN_A = 1'b0;
        tick();
        check("l2_keep_valid", bus1.Rd_Valid_A, 1'b1);
        check("l2_keep_data", bus1.BRAM_Din_A, v[1]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
